// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//
// Shares one SRAM-like bus between the instruction-cache and data-cache
// master ports. Address phases are arbitrated (data over inst by default).
// A small in-order ID FIFO records which master owns each accepted
// transaction, so every data_ok/rdata goes back to the right master.
//
// Configuration macro:
//   SRAM_ARB_RR_EN - when defined, a contended grant with no lock goes to the
//                    master that did not win the previous address handshake.
//                    When undefined, data has fixed priority over inst.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wdata      instruction master request fields
//   inst_rdata/addr_ok/data_ok       instruction master return fields
//   data_req/wr/size/addr/wdata      data master request fields
//   data_rdata/addr_ok/data_ok       data master return fields
//   m_req/wr/size/addr/wdata         request fields driven to the shared bus
//   m_rdata/addr_ok/data_ok          return fields from the shared bus

module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PTR_W           = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(MAX_OUTSTANDING);

  // Owner IDs stored in the FIFO and used for the grant
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [PTR_W:0]             count_q, count_d;
  logic                       lock_q, lock_d;
  logic                       lockOwner_q, lockOwner_d;
`ifdef SRAM_ARB_RR_EN
  logic                       rrLast_q, rrLast_d;
`endif

  logic notFull;
  logic grant;
  logic grantedReq;
  logic push;
  logic pop;
  logic headId;

  // The grant decision is based on the registered count only, so a pop in a
  // full cycle cannot open a grant until the following cycle.
  assign notFull = (count_q < FULL_COUNT);

  // Grant selection: a stalled request keeps its owner so the bus fields stay
  // stable until the address is accepted.
  always_comb begin
    grant = OWNER_INST;
    if (lock_q) begin
      grant = lockOwner_q;
    end
`ifdef SRAM_ARB_RR_EN
    else if (inst_req && data_req) begin
      grant = ~rrLast_q;
    end
`endif
    else begin
      grant = data_req ? OWNER_DATA : OWNER_INST;
    end
  end

  assign grantedReq = (grant == OWNER_DATA) ? data_req : inst_req;

  // Handshakes are gated by rst so they read 0 while reset is held, even
  // though the master request inputs may still be active.
  assign m_req = rst & notFull & grantedReq;
  assign push  = m_req & m_addr_ok;
  assign pop   = rst & m_data_ok & (count_q != '0);

  assign headId = fifo_q[head_q];

  assign inst_addr_ok = push & (grant == OWNER_INST);
  assign data_addr_ok = push & (grant == OWNER_DATA);
  assign inst_data_ok = pop & (headId == OWNER_INST);
  assign data_data_ok = pop & (headId == OWNER_DATA);

  assign inst_rdata = rst ? m_rdata : 32'h0;
  assign data_rdata = rst ? m_rdata : 32'h0;

  // Request-field mux from the granted master, forced to 0 during reset.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (rst) begin
      if (grant == OWNER_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  // Next-state: ID FIFO pointers/count, and the lock that holds a stalled
  // grant. A push and pop in the same cycle leave the count unchanged.
  always_comb begin
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    lock_d      = lock_q;
    lockOwner_d = lockOwner_q;

    if (push) begin
      fifo_d[tail_q] = grant;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (m_req && !m_addr_ok) begin
      lock_d      = 1'b1;
      lockOwner_d = grant;
    end else if (push) begin
      lock_d = 1'b0;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember the most recent address-handshake winner for round-robin.
  always_comb begin
    rrLast_d = rrLast_q;
    if (push) begin
      rrLast_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrLast_q <= OWNER_INST;
    end else begin
      rrLast_q <= rrLast_d;
    end
  end
`endif

  // State registers; reset discards any outstanding transactions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      lock_q      <= 1'b0;
      lockOwner_q <= OWNER_INST;
    end else begin
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      lock_q      <= lock_d;
      lockOwner_q <= lockOwner_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
//
// Directed testbench for sram_bus_arbiter (default build, fixed data-over-inst
// priority, MAX_OUTSTANDING = 4). Inputs change 1 time unit after the rising
// edge and outputs are compared 1 time unit after that.

module tb_sram_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  int checks   = 0;
  int failures = 0;

  sram_bus_arbiter #(.MAX_OUTSTANDING(4), .PTR_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive every master and bus input for one cycle, then let logic settle.
  task automatic applyStimulus(
    input logic        ireq,
    input logic        iwr,
    input logic [31:0] iaddr,
    input logic        dreq,
    input logic        dwr,
    input logic [31:0] daddr,
    input logic [31:0] dwdata,
    input logic        aok,
    input logic        dok,
    input logic [31:0] rdata
  );
    inst_req   = ireq;
    inst_wr    = iwr;
    inst_addr  = iaddr;
    inst_wdata = 32'h0;
    inst_size  = 2'b10;
    data_req   = dreq;
    data_wr    = dwr;
    data_addr  = daddr;
    data_wdata = dwdata;
    data_size  = 2'b01;
    m_addr_ok  = aok;
    m_data_ok  = dok;
    m_rdata    = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic expOwner [4];

    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h1234_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hAAAA_5555);

    // Reset: all handshakes and data outputs held at 0
    checkOutput("rst_m_req",        m_req,        0);
    checkOutput("rst_inst_addr_ok", inst_addr_ok, 0);
    checkOutput("rst_data_addr_ok", data_addr_ok, 0);
    checkOutput("rst_inst_data_ok", inst_data_ok, 0);
    checkOutput("rst_data_data_ok", data_data_ok, 0);
    checkOutput("rst_m_addr",       m_addr,       0);
    checkOutput("rst_inst_rdata",   inst_rdata,   0);

    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    rst = 1'b1;

    // Single inst read at the boot vector
    applyStimulus(1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t1_m_req",        m_req,        1);
    checkOutput("t1_m_addr",       m_addr,       32'hBFC0_0000);
    checkOutput("t1_m_size",       m_size,       2'b10);
    checkOutput("t1_inst_addr_ok", inst_addr_ok, 1);
    checkOutput("t1_data_addr_ok", data_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_idle_inst_data_ok", inst_data_ok, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C08_0001);
    checkOutput("t1_inst_data_ok", inst_data_ok, 1);
    checkOutput("t1_inst_rdata",   inst_rdata,   32'h3C08_0001);
    checkOutput("t1_data_rdata",   data_rdata,   32'h3C08_0001);
    checkOutput("t1_data_data_ok", data_data_ok, 0);

    // Stray data_ok with nothing outstanding is ignored
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0000);
    checkOutput("stray_inst_data_ok", inst_data_ok, 0);
    checkOutput("stray_data_data_ok", data_data_ok, 0);

    // Both request together: data first, then inst; returns in order
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_m_addr",       m_addr,       32'h2000);
    checkOutput("t2_m_wr",         m_wr,         1);
    checkOutput("t2_m_wdata",      m_wdata,      32'hDEAD_BEEF);
    checkOutput("t2_m_size",       m_size,       2'b01);
    checkOutput("t2_data_addr_ok", data_addr_ok, 1);
    checkOutput("t2_inst_addr_ok", inst_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t2b_m_addr",       m_addr,       32'h1000);
    checkOutput("t2b_m_wr",         m_wr,         0);
    checkOutput("t2b_inst_addr_ok", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    checkOutput("t2_ret1_data_data_ok", data_data_ok, 1);
    checkOutput("t2_ret1_inst_data_ok", inst_data_ok, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222_2222);
    checkOutput("t2_ret2_inst_data_ok", inst_data_ok, 1);
    checkOutput("t2_ret2_data_data_ok", data_data_ok, 0);
    checkOutput("t2_ret2_inst_rdata",   inst_rdata,   32'h2222_2222);

    // Lock hold on a stalled data request while inst rises
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_m_req",        m_req,        1);
    checkOutput("t3_m_addr_c1",    m_addr,       32'h2000);
    checkOutput("t3_data_addr_ok", data_addr_ok, 0);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_m_addr_wait",       m_addr,       32'h2000);
      checkOutput("t3_inst_addr_ok_wait", inst_addr_ok, 0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_acc_data_addr_ok", data_addr_ok, 1);
    checkOutput("t3_acc_inst_addr_ok", inst_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_inst_m_addr",    m_addr,       32'h3000);
    checkOutput("t3_inst_addr_ok",   inst_addr_ok, 1);

    // Lock holds a stalled inst request against higher-priority data
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h4000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3i_m_addr_c1", m_addr, 32'h4000);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h4000, 1'b1, 1'b0, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3i_m_addr_locked", m_addr,       32'h4000);
    checkOutput("t3i_data_addr_ok",  data_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h4000, 1'b1, 1'b0, 32'h5000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3i_acc_inst_addr_ok", inst_addr_ok, 1);
    checkOutput("t3i_acc_data_addr_ok", data_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3i_data_m_addr",    m_addr,       32'h5000);
    checkOutput("t3i_data_addr_ok",   data_addr_ok, 1);

    // Four outstanding: further requests are held off
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h6000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_full_m_req",        m_req,        0);
    checkOutput("t3_full_inst_addr_ok", inst_addr_ok, 0);

    // Drain in issue order: data, inst, inst, data
    expOwner = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3000_0000 + k);
      checkOutput("t3_drain_data_data_ok", data_data_ok, expOwner[k]);
      checkOutput("t3_drain_inst_data_ok", inst_data_ok, !expOwner[k]);
    end

    // Fill with four inst reads, then a pop reopens the grant a cycle later
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h8000 + 4 * k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_fill_inst_addr_ok", inst_addr_ok, 1);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h8010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_full_m_req",        m_req,        0);
    checkOutput("t4_full_inst_addr_ok", inst_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h8010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4444_4444);
    checkOutput("t4_pop_m_req",        m_req,        0);
    checkOutput("t4_pop_inst_data_ok", inst_data_ok, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h8010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_resume_m_req",        m_req,        1);
    checkOutput("t4_resume_inst_addr_ok", inst_addr_ok, 1);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5000_0000 + k);
      checkOutput("t4_drain_inst_data_ok", inst_data_ok, 1);
    end

    // Push and pop in the same cycle at two outstanding
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_d_addr_ok", data_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'hB000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_i_addr_ok", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC000, 32'h0, 1'b1, 1'b1, 32'h7777_7777);
    checkOutput("t5_pp_data_addr_ok", data_addr_ok, 1);
    checkOutput("t5_pp_data_data_ok", data_data_ok, 1);
    checkOutput("t5_pp_inst_data_ok", inst_data_ok, 0);
    checkOutput("t5_pp_data_rdata",   data_rdata,   32'h7777_7777);
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'hD000 + 4 * k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_top_inst_addr_ok", inst_addr_ok, 1);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'hD008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_full_m_req", m_req, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8888_8888);
    checkOutput("t5_pop_inst_data_ok", inst_data_ok, 1);
    checkOutput("t5_pop_data_data_ok", data_data_ok, 0);

    // Reset with three outstanding: outputs drop immediately
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'hE000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h5555_5555);
    checkOutput("t6_m_req",        m_req,        0);
    checkOutput("t6_inst_addr_ok", inst_addr_ok, 0);
    checkOutput("t6_inst_data_ok", inst_data_ok, 0);
    checkOutput("t6_data_data_ok", data_data_ok, 0);
    checkOutput("t6_inst_rdata",   inst_rdata,   0);
    checkOutput("t6_m_addr",       m_addr,       0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_new_inst_addr_ok", inst_addr_ok, 1);
    checkOutput("t6_new_m_addr",       m_addr,       32'hBFC0_0004);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("t6_new_inst_data_ok", inst_data_ok, 1);
    checkOutput("t6_new_inst_rdata",   inst_rdata,   32'h1234_5678);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    checkOutput("t6_empty_inst_data_ok", inst_data_ok, 0);
    checkOutput("t6_empty_data_data_ok", data_data_ok, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
